// File: rtl/lcd_timing_gen.sv
// Raster timing generator. It waits for the PLL to lock, lets the clock settle,
// then produces sync, data-enable and pixel coordinates, all registered.
module lcd_timing_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit HS_POL    = 1'b0,
  parameter bit VS_POL    = 1'b0,
  parameter int LOCK_WAIT = 1024
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       locked,
  output logic       hsync,
  output logic       vsync,
  output logic       de,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       frame_start,
  output logic       running
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0]  H_LAST      = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST      = 10'(V_TOTAL - 1);
  localparam logic [10:0] H_ACT_END   = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT_END   = 11'(V_ACTIVE);
  localparam logic [10:0] HS_START    = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END      = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_START    = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END      = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [15:0] SETTLE_LAST = 16'(LOCK_WAIT - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK,
    SETTLE,
    RUN
  } state_t;

  state_t      r_state;
  logic        r_lock_meta;
  logic        r_lock_s;
  logic [15:0] r_settle_cnt;
  logic [9:0]  r_h_cnt;
  logic [9:0]  r_v_cnt;

  logic        w_de;
  logic        w_hs_act;
  logic        w_vs_act;
  logic        w_origin;

  // Stage 0: bring the asynchronous lock flag into the pixel-clock domain
  always_ff @(posedge clock) begin
    if (reset) begin
      r_lock_meta <= 1'b0;
      r_lock_s    <= 1'b0;
    end else begin
      r_lock_meta <= locked;
      r_lock_s    <= r_lock_meta;
    end
  end

  // Stage 1: lock/settle/run sequencing and raster counters
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= WAIT_LOCK;
      r_settle_cnt <= 16'd0;
      r_h_cnt      <= 10'd0;
      r_v_cnt      <= 10'd0;
      running      <= 1'b0;
    end else begin
      case (r_state)
        WAIT_LOCK: begin
          if (r_lock_s) begin
            r_state      <= SETTLE;
            r_settle_cnt <= 16'd0;
          end
        end
        SETTLE: begin
          if (!r_lock_s) begin
            r_state <= WAIT_LOCK;
          end else if (r_settle_cnt == SETTLE_LAST) begin
            r_state <= RUN;
            r_h_cnt <= 10'd0;
            r_v_cnt <= 10'd0;
            running <= 1'b1;
          end else begin
            r_settle_cnt <= r_settle_cnt + 16'd1;
          end
        end
        RUN: begin
          if (!r_lock_s) begin
            r_state <= WAIT_LOCK;
            r_h_cnt <= 10'd0;
            r_v_cnt <= 10'd0;
            running <= 1'b0;
          end else if (r_h_cnt == H_LAST) begin
            r_h_cnt <= 10'd0;
            r_v_cnt <= (r_v_cnt == V_LAST) ? 10'd0 : r_v_cnt + 10'd1;
          end else begin
            r_h_cnt <= r_h_cnt + 10'd1;
          end
        end
        default: begin
          r_state <= WAIT_LOCK;
          running <= 1'b0;
        end
      endcase
    end
  end

  // Decode compares are one bit wider so a region ending at 1024 still works
  assign w_de     = ({1'b0, r_h_cnt} < H_ACT_END) && ({1'b0, r_v_cnt} < V_ACT_END);
  assign w_hs_act = ({1'b0, r_h_cnt} >= HS_START) && ({1'b0, r_h_cnt} < HS_END);
  assign w_vs_act = ({1'b0, r_v_cnt} >= VS_START) && ({1'b0, r_v_cnt} < VS_END);
  assign w_origin = (r_h_cnt == 10'd0) && (r_v_cnt == 10'd0);

  // Stage 2: registered pin outputs, forced idle outside RUN
  always_ff @(posedge clock) begin
    if (reset || (r_state != RUN)) begin
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      de          <= 1'b0;
      x           <= 10'd0;
      y           <= 10'd0;
      frame_start <= 1'b0;
    end else begin
      hsync       <= w_hs_act ? HS_POL : ~HS_POL;
      vsync       <= w_vs_act ? VS_POL : ~VS_POL;
      de          <= w_de;
      x           <= w_de ? r_h_cnt : 10'd0;
      y           <= w_de ? r_v_cnt : 10'd0;
      frame_start <= w_de && w_origin;
    end
  end

endmodule
